// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, bubble
// insertion and a saturating stall counter.
// Build option: define PIPE_STAGE_SKID_EN to compile in the 2-entry skid
// buffer with a registered in_ready; otherwise a single-entry stage with
// combinational in_ready is built. The port list is the same in both builds.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 146,
  parameter logic [DATA_W-1:0] NOP_VALUE   = {DATA_W{1'b0}},
  parameter int unsigned       STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              in_fire;
  logic              out_fire;

  // The main register is the only thing that ever drives the outputs.
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_fire  = main_valid && out_ready;
  assign in_fire   = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  // Ready depends only on skid occupancy, so there is no path from out_ready.
  assign in_ready = !skid_valid;

  // Main/skid update: skid drains into main first; new data parks in skid when main is stuck.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
      skid_valid <= 1'b0;
      skid_data  <= NOP_VALUE;
    end else if (skid_valid) begin
      if (out_fire) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= NOP_VALUE;
      end
    end else if (in_fire) begin
      if (main_valid && !out_ready) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
    end
  end

`else

  // Single entry: room exists when empty or when the current entry leaves this cycle.
  assign in_ready = !main_valid || out_ready;

  // Main update: load on input handshake, otherwise drop to a NOP bubble when drained.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
    end else if (in_fire) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (out_fire) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
    end
  end

`endif

  // Stall counter: counts blocked valid cycles, saturates, ignores flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed bench for pipe_stage_reg,
// checked against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 146;
  localparam logic [DATA_W-1:0] NOP = '0;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       stall_cnt;

  logic              sat_in_ready;
  logic              sat_out_valid;
  logic [DATA_W-1:0] sat_out_data;
  logic [3:0]        sat_stall_cnt;

  int vec_count  = 0;
  int fail_count = 0;

  logic [DATA_W-1:0] model_q[$];
  longint            model_cnt;
  int                model_cnt4;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.STALL_CNT_W(4)) sat_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .stall_cnt(sat_stall_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    vec_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, then advance the model.
  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [DATA_W-1:0] d, input logic ordy);
    logic              exp_ready;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_valid = (model_q.size() > 0);
    exp_data  = exp_valid ? model_q[0] : NOP;
    if (CAP == 2) exp_ready = (model_q.size() < 2);
    else          exp_ready = (model_q.size() == 0) || ordy;
    checkOutput("in_ready",      {159'd0, in_ready},      {159'd0, exp_ready});
    checkOutput("out_valid",     {159'd0, out_valid},     {159'd0, exp_valid});
    checkOutput("out_data",      {14'd0, out_data},       {14'd0, exp_data});
    checkOutput("stall_cnt",     {128'd0, stall_cnt},     {96'd0, model_cnt});
    checkOutput("sat_stall_cnt", {156'd0, sat_stall_cnt}, 160'(model_cnt4));
    checkOutput("sat_out_data",  {14'd0, sat_out_data},   {14'd0, exp_data});
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_cnt  = 0;
      model_cnt4 = 0;
    end else begin
      if (exp_valid && !ordy) begin
        if (model_cnt < 64'h0000_0000_FFFF_FFFF) model_cnt++;
        if (model_cnt4 < 15) model_cnt4++;
      end
      if (f) begin
        model_q.delete();
      end else begin
        if (exp_valid && ordy) void'(model_q.pop_front());
        if (iv && exp_ready) model_q.push_back(d);
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] randData();
    logic [159:0] wide;
    wide = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return wide[DATA_W-1:0];
  endfunction

  // Directed scenarios followed by a long randomized run.
  initial begin
    model_cnt  = 0;
    model_cnt4 = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 'h1234; out_ready = 1'b1;
    @(posedge clk);

    // reset held a second cycle, then released
    applyStimulus(1, 0, 1, 'h1234, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // back-to-back stream
    applyStimulus(0, 0, 1, 'd1, 1);
    applyStimulus(0, 0, 1, 'd2, 1);
    applyStimulus(0, 0, 1, 'd3, 1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // back-pressure for three cycles
    applyStimulus(0, 0, 1, 'hA, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 'hB, 0);
    #1;
    checkOutput("bp_stall_cnt", {128'd0, stall_cnt}, 160'd3);
    applyStimulus(0, 0, 1, 'hB, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1);

    // flush while stalled
    applyStimulus(0, 0, 1, 'hA, 1);
    applyStimulus(0, 0, 1, 'hB, 0);
    applyStimulus(0, 1, 1, 'hC, 0);
    #1;
    checkOutput("flush_valid", {159'd0, out_valid}, 160'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1);

    // single payload followed by a bubble
    applyStimulus(0, 0, 1, 'h5, 1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // narrow counter saturation
    applyStimulus(0, 0, 1, 'h77, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, '0, 0);
    #1;
    checkOutput("sat_at_15", {156'd0, sat_stall_cnt}, 160'd15);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 1),
                    ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 70),
                    randData(),
                    ($urandom_range(0, 99) < 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for GeMIPS, the successor to the fixed-field ID/EX latch. It carries an arbitrary-width packed bundle (alusel, aluop, operands, write address/enable, link address, instruction) between two pipeline stages. It uses a valid/ready handshake, so back-pressure stalls the stage instead of overwriting it. It adds synchronous flush with bubble (NOP) insertion, an optional 2-entry skid buffer, and a saturating stall counter. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 146, width of the packed payload (default is the ID/EX bundle: 4+8+32+32+5+1+32+32).
- NOP_VALUE, {DATA_W{1'b0}}, payload driven on reset, flush and bubble (encodes ALU_SEL_NOP/ALU_OP_NOP, we=0).
- STALL_CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  this stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is a valid instruction.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_W  registered payload.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Input handshake fires when in_valid and in_ready. Output handshake fires when out_valid and out_ready.
- Main register (valid bit + payload) always drives out_valid/out_data. It is never combinational from in_data.
- Priority per cycle: rst > flush > normal update.
- rst: out_valid=0, out_data=NOP_VALUE, skid emptied, stall_cnt=0.
- flush: all valid bits cleared and the main payload becomes NOP_VALUE on the next edge. An input handshake in the flush cycle is discarded. in_ready is not gated by flush. stall_cnt is unaffected.
- Bubble: when the main register empties with no new input, out_valid=0 and out_data=NOP_VALUE. A stale payload is never held.
- stall_cnt increments when out_valid && !out_ready, saturates at all-ones, and is cleared only by rst.
- Payload is opaque; no arithmetic on it. The counter is unsigned with no wrap.

## Timing
- Latency: 1 cycle. A payload accepted at edge N appears on out_data after edge N.
- Without skid: in_ready = !out_valid || out_ready (combinational from out_ready). Full throughput, 1 entry.
  - Full and out_ready=0: in_ready=0 and the main register holds.
  - Simultaneous output fire and input fire: the main register loads the new payload, out_valid stays 1.
  - Output fire with no input: out_valid becomes 0.
- With skid: in_ready = !skid_valid, a registered value with no path from out_ready. Capacity 2.
  - Input fires while main is valid and not firing: payload goes to skid, skid_valid=1.
  - Output fires with skid valid: main <= skid, skid_valid=0. Any input that cycle would find in_ready=0.
  - Output fires, skid empty, input fires: main <= in_data.
  - Both empty and input fires: main <= in_data.
- Reset or flush mid-stall: both entries are dropped the same edge. in_ready=1 on the next cycle.
- After rst deassert: out_valid=0, in_ready=1, stall_cnt=0.

## Configuration
- PIPE_STAGE_SKID_EN defined: the 2-entry skid buffer is compiled in, and in_ready is registered, breaking the ready timing path between stages.
- Not defined: single-entry stage with combinational in_ready as above. The skid register is not instantiated. Port list is identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_data=0x1234 -> out_valid=0, out_data=NOP_VALUE, stall_cnt=0, in_ready=1 after release.
- Stream: in_valid=1 with payloads 1,2,3 on consecutive cycles, out_ready=1 -> out_data 1,2,3 one cycle later, back-to-back, out_valid=1 throughout.
- Back-pressure: send payload 0xA, drop out_ready for 3 cycles.
  - Without skid: in_ready=0 and out_data holds 0xA.
  - With skid: payload 0xB is accepted into skid, then in_ready=0.
  - In both builds: stall_cnt=3, and 0xA then 0xB emerge in order after out_ready=1.
- Flush during stall: with 0xA in main and 0xB in skid, pulse flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=NOP_VALUE, and 0xC is never output.
- Bubble: single payload 0x5 followed by in_valid=0, out_ready=1 -> 0x5 is valid for one cycle, then out_valid=0 with out_data=NOP_VALUE.
- Saturation: STALL_CNT_W=4 with out_ready=0 for 20 cycles while valid -> stall_cnt stops at 15.
